// File: rtl/cpu_datapath.sv
// cpu_datapath: register file R0..R7, ALU and flag register for the small CPU.
// Latency: A/B reads and F are combinational; register writes and psw land on the next clk rise.
// Backpressure: none; every non-NOP control word is executed the cycle it is presented.
//
// Ports:
//   clk, rst_n  - single clock, asynchronous active-low reset
//   mode        - control word {DA[12:10], AA[9:7], BA[6:4], FS[3:1], RW[0]}
//   ir_ops      - instruction operand field; [8:0] is the 9-bit immediate for LDI
//   mem_din     - memory read data for LD
//   psw         - registered flags {z, n, c, v}
//   addr_out    - A-bus (memory address)
//   data_out    - B-bus (memory write data)
//   f_out       - combinational function result F
// BW must be at least 9 so the immediate fits.

module cpu_datapath #(
  parameter int BW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [12:0]   mode,
  input  logic [16:0]   ir_ops,
  input  logic [BW-1:0] mem_din,
  output logic [3:0]    psw,
  output logic [BW-1:0] addr_out,
  output logic [BW-1:0] data_out,
  output logic [BW-1:0] f_out
);

  localparam logic [2:0] FS_ADD = 3'b000;
  localparam logic [2:0] FS_SUB = 3'b001;
  localparam logic [2:0] FS_AND = 3'b010;
  localparam logic [2:0] FS_OR  = 3'b011;
  localparam logic [2:0] FS_XOR = 3'b100;
  localparam logic [2:0] FS_SHR = 3'b101;
  localparam logic [2:0] FS_LDI = 3'b110;
  localparam logic [2:0] FS_LD  = 3'b111;

  logic [2:0] da, aa, ba, fs;
  logic       rw;

  assign da = mode[12:10];
  assign aa = mode[9:7];
  assign ba = mode[6:4];
  assign fs = mode[3:1];
  assign rw = mode[0];

  // Upper operand bits are not used by the datapath.
  logic unused_ops;
  assign unused_ops = ^ir_ops[16:9];

  // R0 is not stored: it is hardwired to zero on read.
  logic [BW-1:0] rf [1:7];
  logic [BW-1:0] a, b;

  assign a = (aa == 3'd0) ? '0 : rf[aa];
  assign b = (ba == 3'd0) ? '0 : rf[ba];

  assign addr_out = a;
  assign data_out = b;

  // ALU: one extra bit on add/sub captures carry-out and borrow respectively.
  logic [BW:0]   sum, diff;
  logic [BW-1:0] f;
  logic          c_flag, v_flag;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    f      = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (fs)
      FS_ADD: begin
        f      = sum[BW-1:0];
        c_flag = sum[BW];
        v_flag = (a[BW-1] == b[BW-1]) && (sum[BW-1] != a[BW-1]);
      end
      FS_SUB: begin
        f      = diff[BW-1:0];
        c_flag = diff[BW];
        v_flag = (a[BW-1] != b[BW-1]) && (diff[BW-1] != a[BW-1]);
      end
      FS_AND: f = a & b;
      FS_OR:  f = a | b;
      FS_XOR: f = a ^ b;
      FS_SHR: begin
        f      = {1'b0, a[BW-1:1]};
        c_flag = a[0];
      end
      FS_LDI: f = {{(BW-9){1'b0}}, ir_ops[8:0]};
      FS_LD:  f = mem_din;
      default: f = '0;
    endcase
  end

  assign f_out = f;

  // Flags update for the ALU ops regardless of RW, so SUB with RW=0 is a compare.
  // LDI/LD and the all-zero NOP word leave them alone.
  logic flag_upd;
  assign flag_upd = (mode != 13'd0) && (fs != FS_LDI) && (fs != FS_LD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psw <= 4'b0000;
    end else if (flag_upd) begin
      psw <= {(f == '0), f[BW-1], c_flag, v_flag};
    end
  end

  // mode==0 has RW=0, so the NOP case needs no extra qualification here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 8; i++) begin
        rf[i] <= '0;
      end
    end else if (rw && (da != 3'd0)) begin
      rf[da] <= f;
    end
  end

endmodule

// File: tb/tb_cpu_datapath.sv
// tb_cpu_datapath: self-checking bench for cpu_datapath (BW=16).
// Latency: checks F/A/B before each edge and psw/registers after it.
// Backpressure: none; one control word per cycle, driven on the falling edge.

module tb_cpu_datapath;

  logic        clk;
  logic        rst_n;
  logic [12:0] mode;
  logic [16:0] ir_ops;
  logic [15:0] mem_din;
  logic [3:0]  psw;
  logic [15:0] addr_out;
  logic [15:0] data_out;
  logic [15:0] f_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: plain array of register values plus the flag nibble.
  logic [15:0] m_r [8];
  logic [3:0]  m_psw;

  cpu_datapath #(.BW(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .ir_ops   (ir_ops),
    .mem_din  (mem_din),
    .psw      (psw),
    .addr_out (addr_out),
    .data_out (data_out),
    .f_out    (f_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] mk(input int da, input int aa, input int ba,
                                     input int fs, input int rw);
    logic [12:0] m;
    m[12:10] = 3'(da);
    m[9:7]   = 3'(aa);
    m[6:4]   = 3'(ba);
    m[3:1]   = 3'(fs);
    m[0]     = 1'(rw);
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0000;
    m_psw = 4'b0000;
  endtask

  // Evaluate an op with integer arithmetic; signed overflow is judged by range.
  task automatic model_eval(input logic [12:0] md, input logic [16:0] ops,
                            input logic [15:0] din, output logic [15:0] f,
                            output logic [3:0] flags);
    int a, b, sa, sb, r, sr;
    bit c, v;
    a  = int'(m_r[md[9:7]]);
    b  = int'(m_r[md[6:4]]);
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    c  = 0;
    v  = 0;
    r  = 0;
    case (md[3:1])
      3'd0: begin r = a + b; c = (r > 65535); sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
      3'd1: begin r = a - b; c = (a < b);     sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = a / 2; c = (a % 2) == 1; end
      3'd6: r = int'(ops[8:0]);
      default: r = int'(din);
    endcase
    f     = 16'(r & 32'hFFFF);
    flags = {(f == 16'h0000), (f >= 16'h8000), c, v};
  endtask

  // Apply one control word for one cycle, checking buses before and state after the edge.
  task automatic do_op(input logic [12:0] md, input logic [16:0] ops, input logic [15:0] din);
    logic [15:0] ef;
    logic [3:0]  efl;
    @(negedge clk);
    mode = md; ir_ops = ops; mem_din = din;
    model_eval(md, ops, din, ef, efl);
    #1;
    n_cmp++;
    if (f_out !== ef) begin n_bad++; $display("FAIL op_f mode=%h got %h want %h", md, f_out, ef); end
    n_cmp++;
    if (addr_out !== m_r[md[9:7]]) begin n_bad++; $display("FAIL op_addr mode=%h got %h want %h", md, addr_out, m_r[md[9:7]]); end
    n_cmp++;
    if (data_out !== m_r[md[6:4]]) begin n_bad++; $display("FAIL op_data mode=%h got %h want %h", md, data_out, m_r[md[6:4]]); end
    @(posedge clk);
    #1;
    if (md != 13'd0 && md[3:1] != 3'd6 && md[3:1] != 3'd7) m_psw = efl;
    if (md[0] && md[12:10] != 3'd0) m_r[md[12:10]] = ef;
    n_cmp++;
    if (psw !== m_psw) begin n_bad++; $display("FAIL op_psw mode=%h got %b want %b", md, psw, m_psw); end
  endtask

  // Read register r on the A-bus with a side-effect-free word (LDI, RW=0).
  task automatic read_reg(input int r, output logic [15:0] val);
    @(negedge clk);
    mode = mk(0, r, 0, 6, 0);
    #1;
    val = addr_out;
  endtask

  task automatic check_all_regs(input string tag);
    logic [15:0] val;
    for (int r = 0; r < 8; r++) begin
      read_reg(r, val);
      n_cmp++;
      if (val !== m_r[r]) begin n_bad++; $display("FAIL %s R%0d got %h want %h", tag, r, val, m_r[r]); end
    end
  endtask

  task automatic test_reset();
    logic [15:0] val;
    rst_n = 1'b0; mode = 13'd0; ir_ops = 17'd0; mem_din = 16'd0;
    model_reset();
    #12;
    n_cmp++;
    if (psw !== 4'b0000) begin n_bad++; $display("FAIL reset_psw got %b want 0000", psw); end
    mode = mk(0, 3, 5, 6, 0); ir_ops = 17'h0_0155;
    #1;
    n_cmp++;
    if (f_out !== 16'h0155) begin n_bad++; $display("FAIL reset_f_ldi got %h want 0155", f_out); end
    n_cmp++;
    if (addr_out !== 16'h0000 || data_out !== 16'h0000) begin
      n_bad++; $display("FAIL reset_buses got %h/%h want 0000/0000", addr_out, data_out);
    end
    mode = mk(0, 0, 0, 7, 0); mem_din = 16'hBEEF;
    #1;
    n_cmp++;
    if (f_out !== 16'hBEEF) begin n_bad++; $display("FAIL reset_f_ld got %h want beef", f_out); end
    @(negedge clk);
    rst_n = 1'b1;
    read_reg(7, val);
    n_cmp++;
    if (val !== 16'h0000) begin n_bad++; $display("FAIL reset_r7 got %h want 0000", val); end
  endtask

  task automatic test_ldi_add();
    logic [15:0] val;
    do_op(mk(1, 0, 0, 6, 1), 17'h1_01FF, 16'h0);
    do_op(mk(2, 0, 0, 6, 1), 17'h0_0001, 16'h0);
    do_op(mk(3, 1, 2, 0, 1), 17'h0, 16'h0);
    read_reg(3, val);
    n_cmp++;
    if (val !== 16'h0200) begin n_bad++; $display("FAIL ldi_add_r3 got %h want 0200", val); end
    n_cmp++;
    if (psw !== 4'b0000) begin n_bad++; $display("FAIL ldi_add_psw got %b want 0000", psw); end
  endtask

  task automatic test_carry_wrap();
    logic [15:0] val;
    do_op(mk(1, 0, 0, 7, 1), 17'h0, 16'hFFFF);
    do_op(mk(2, 0, 0, 6, 1), 17'h0_0001, 16'h0);
    do_op(mk(3, 1, 2, 0, 1), 17'h0, 16'h0);
    read_reg(3, val);
    n_cmp++;
    if (val !== 16'h0000) begin n_bad++; $display("FAIL wrap_r3 got %h want 0000", val); end
    n_cmp++;
    if (psw !== 4'b1010) begin n_bad++; $display("FAIL wrap_psw got %b want 1010", psw); end
  endtask

  task automatic test_overflow_cmp();
    logic [15:0] val;
    do_op(mk(1, 0, 0, 7, 1), 17'h0, 16'h7FFF);
    do_op(mk(2, 0, 0, 7, 1), 17'h0, 16'hFFFF);
    do_op(mk(3, 1, 2, 1, 0), 17'h0, 16'h0);
    n_cmp++;
    if (psw !== 4'b0111) begin n_bad++; $display("FAIL cmp_psw got %b want 0111", psw); end
    read_reg(3, val);
    n_cmp++;
    if (val !== 16'h0000) begin n_bad++; $display("FAIL cmp_r3_untouched got %h want 0000", val); end
    check_all_regs("cmp_regs");
  endtask

  task automatic test_r0_nop();
    logic [15:0] val;
    do_op(mk(0, 0, 0, 7, 1), 17'h0, 16'h1234);
    read_reg(0, val);
    n_cmp++;
    if (val !== 16'h0000) begin n_bad++; $display("FAIL r0_read got %h want 0000", val); end
    do_op(mk(3, 1, 2, 1, 0), 17'h0, 16'h0);   // flags 0111 again
    do_op(13'd0, 17'h0, 16'h0);
    n_cmp++;
    if (psw !== 4'b0111) begin n_bad++; $display("FAIL nop_psw got %b want 0111", psw); end
  endtask

  task automatic test_shr_ld();
    logic [15:0] val;
    do_op(mk(1, 0, 0, 6, 1), 17'h0_0003, 16'h0);
    do_op(mk(4, 1, 0, 5, 1), 17'h0, 16'h0);
    read_reg(4, val);
    n_cmp++;
    if (val !== 16'h0001) begin n_bad++; $display("FAIL shr_r4 got %h want 0001", val); end
    n_cmp++;
    if (psw !== 4'b0010) begin n_bad++; $display("FAIL shr_psw got %b want 0010", psw); end
    do_op(mk(5, 0, 0, 7, 1), 17'h0, 16'hA5A5);
    read_reg(5, val);
    n_cmp++;
    if (val !== 16'hA5A5) begin n_bad++; $display("FAIL ld_r5 got %h want a5a5", val); end
    n_cmp++;
    if (psw !== 4'b0010) begin n_bad++; $display("FAIL ld_psw got %b want 0010", psw); end
  endtask

  task automatic test_random();
    logic [12:0] md;
    for (int i = 0; i < 400; i++) begin
      md = 13'($urandom);
      if ($urandom_range(0, 9) == 0) md = 13'd0;
      do_op(md, 17'($urandom), 16'($urandom));
      if (i % 100 == 99) check_all_regs("rand_regs");
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] val;
    do_op(mk(1, 0, 0, 7, 1), 17'h0, 16'h8001);
    do_op(mk(6, 1, 1, 0, 0), 17'h0, 16'h0);   // psw becomes non-zero (c,v set)
    @(negedge clk);
    mode = mk(6, 1, 1, 6, 1); ir_ops = 17'h0_00AB;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if (psw !== 4'b0000) begin n_bad++; $display("FAIL arst_psw got %b want 0000", psw); end
    n_cmp++;
    if (addr_out !== 16'h0000) begin n_bad++; $display("FAIL arst_addr got %h want 0000", addr_out); end
    n_cmp++;
    if (f_out !== 16'h00AB) begin n_bad++; $display("FAIL arst_f got %h want 00ab", f_out); end
    @(posedge clk);
    #1;
    read_reg(6, val);
    n_cmp++;
    if (val !== 16'h0000) begin n_bad++; $display("FAIL arst_write_lost got %h want 0000", val); end
    check_all_regs("arst_regs");
    @(negedge clk);
    rst_n = 1'b1;
    do_op(mk(6, 0, 0, 6, 1), 17'h0_0123, 16'h0);
    read_reg(6, val);
    n_cmp++;
    if (val !== 16'h0123) begin n_bad++; $display("FAIL post_reset_write got %h want 0123", val); end
  endtask

  initial begin
    test_reset();
    test_ldi_add();
    test_carry_wrap();
    test_overflow_cmp();
    test_r0_nop();
    test_shr_ld();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog: the sequence is a few thousand cycles at most.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 The block SHALL have parameter BW, default 16, giving the data word width (register, bus and ALU width).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port mode, input, 13 bits: control word from cpu_cont.
- [12:10] DA, destination register.
- [9:7] AA, A-source register.
- [6:4] BA, B-source register.
- [3:1] FS, function select.
- [0] RW, register write enable.
REQ-005 The block SHALL have port ir_ops, input, 17 bits: instruction operand field from cpu_cont; [8:0] is the immediate.
REQ-006 The block SHALL have port mem_din, input, BW bits: memory read data.
REQ-007 The block SHALL have port psw, output, 4 bits: registered flags {z,n,c,v}, bit 3 down to bit 0, feeding cpu_cont.
REQ-008 The block SHALL have port addr_out, output, BW bits: A-bus value, the memory address.
REQ-009 The block SHALL have port data_out, output, BW bits: B-bus value, the memory write data.
REQ-010 The block SHALL have port f_out, output, BW bits: combinational function result F.

Function
REQ-011 The block SHALL hold a register file R0..R7 of BW bits each; R0 SHALL read as 0 and writes to R0 SHALL be ignored.
REQ-012 Reads of registers AA and BA SHALL be combinational, giving A and B.
- addr_out = A, data_out = B.
- A read of a register being written in the same cycle SHALL return the pre-edge value (no bypass).
REQ-013 F SHALL be computed from FS as follows:
- 000 ADD: A+B.
- 001 SUB: A-B.
- 010 AND: A&B.
- 011 OR: A|B.
- 100 XOR: A^B.
- 101 SHR: {0,A[BW-1:1]}.
- 110 LDI: zero-extended ir_ops[8:0].
- 111 LD: mem_din.
REQ-014 All arithmetic SHALL be modulo 2^BW; results SHALL wrap without saturation.
REQ-015 On a rising clk edge with RW=1 and DA!=0, R[DA] SHALL be loaded with F.
REQ-016 mode==0 SHALL be a NOP: no register write and no flag update.
REQ-017 For FS 000..101 with mode!=0, psw SHALL be loaded at the same edge, independent of RW, so that SUB with RW=0 acts as compare.
- z = (F==0).
- n = F[BW-1].
REQ-018 Carry and overflow SHALL be computed per operation:
- ADD: c = carry out of bit BW-1; v = (A[BW-1]==B[BW-1]) && (F[BW-1]!=A[BW-1]).
- SUB: c = 1 iff A<B unsigned (borrow); v = (A[BW-1]!=B[BW-1]) && (F[BW-1]!=A[BW-1]).
- AND/OR/XOR: c=0, v=0.
- SHR: c = A[0], v=0.
REQ-019 FS 110 and 111 SHALL leave psw unchanged.
REQ-020 psw SHALL be visible to cpu_cont one cycle after the updating edge, so a branch tests the flags of the most recent flag-setting operation.

Reset
REQ-021 While rst_n=0, asynchronously and regardless of clk, R1..R7 SHALL be 0 and psw SHALL be 4'b0000.
REQ-022 A reset asserted mid-sequence SHALL discard the in-flight write and flag update.
REQ-023 After rst_n rises, the first rising edge SHALL perform a normal update.
REQ-024 While in reset, addr_out, data_out and f_out SHALL reflect the reset register contents (0), with f_out following FS/ir_ops/mem_din combinationally.

Verification
REQ-025 The bench SHALL cover immediate load and add:
- LDI R1 (imm 9'h1FF), LDI R2 (imm 9'h001), then ADD R3=R1+R2.
- Required: R3=16'h0200; psw=0000.
REQ-026 The bench SHALL cover carry, zero and wrap:
- With R1=16'hFFFF, R2=16'h0001, ADD R3=R1+R2.
- Required: R3=0; psw={z=1,n=0,c=1,v=0}.
REQ-027 The bench SHALL cover signed overflow on compare:
- With R1=16'h7FFF, R2=16'hFFFF, SUB with RW=0.
- Required: no register changes; psw={0,1,1,1}.
REQ-028 The bench SHALL cover the R0 rules and NOP:
- Write to R0 with F=16'h1234, then read R0 on AA: addr_out=0.
- mode=0 after a flag-setting op: psw unchanged.
REQ-029 The bench SHALL cover shift and memory load:
- With R1=16'h0003, SHR R4: R4=16'h0001, c=1.
- LD R5 with mem_din=16'hA5A5: R5=16'hA5A5, psw unchanged.
REQ-030 The bench SHALL cover asynchronous reset mid-operation:
- Drive rst_n low between clock edges while RW=1.
- Required: psw=0 and all registers 0 immediately, without waiting for an edge; the write is lost.
